// File: rtl/mc_pkg.sv
// Shared types and constants for the multicycle controller.
// Holds the state enum, ALU/result/operand-B codes and decode helpers.
package mc_pkg;

    typedef enum logic [3:0] {
        FETCH  = 4'd0,
        DECODE = 4'd1,
        MEMADR = 4'd2,
        MEMRD  = 4'd3,
        MEMWB  = 4'd4,
        MEMWR  = 4'd5,
        EXECR  = 4'd6,
        EXECI  = 4'd7,
        ALUWB  = 4'd8,
        BRANCH = 4'd9
    } state_t;

    localparam logic [1:0] ALU_ADD = 2'b00;
    localparam logic [1:0] ALU_SUB = 2'b01;
    localparam logic [1:0] ALU_AND = 2'b10;
    localparam logic [1:0] ALU_ORR = 2'b11;

    localparam logic [1:0] RES_ALUOUT    = 2'b00;
    localparam logic [1:0] RES_DATA      = 2'b01;
    localparam logic [1:0] RES_ALURESULT = 2'b10;

    localparam logic [1:0] SRCB_REG    = 2'b00;
    localparam logic [1:0] SRCB_EXTIMM = 2'b01;
    localparam logic [1:0] SRCB_PLUS4  = 2'b10;

    localparam logic [1:0] OP_DP  = 2'b00;
    localparam logic [1:0] OP_MEM = 2'b01;
    localparam logic [1:0] OP_BR  = 2'b10;
    localparam logic [1:0] OP_NOP = 2'b11;

    localparam logic [3:0] CMD_AND = 4'b0000;
    localparam logic [3:0] CMD_SUB = 4'b0010;
    localparam logic [3:0] CMD_ADD = 4'b0100;
    localparam logic [3:0] CMD_ORR = 4'b1100;

    // Data-processing commands this core implements.
    function automatic logic dp_ok(input logic [3:0] cmd);
        return (cmd == CMD_AND) || (cmd == CMD_SUB) ||
               (cmd == CMD_ADD) || (cmd == CMD_ORR);
    endfunction

    function automatic logic [1:0] alu_op(input logic [3:0] cmd);
        logic [1:0] r;
        r = ALU_ADD;
        case (cmd)
            CMD_SUB: r = ALU_SUB;
            CMD_AND: r = ALU_AND;
            CMD_ORR: r = ALU_ORR;
            default: r = ALU_ADD;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/mc_controller_if.sv
// Bundle of controller <-> datapath signals.
// master: controller side; slave: datapath/instruction-register side.
interface mc_controller_if;

    logic [31:12] Instr;
    logic [3:0]   ALUFlags;
    logic         MemReady;
    logic         PCWrite;
    logic         IRWrite;
    logic         RegWrite;
    logic         MemWrite;
    logic         AdrSrc;
    logic         ALUSrcA;
    logic [1:0]   ResultSrc;
    logic [1:0]   ALUSrcB;
    logic [1:0]   ImmSrc;
    logic [1:0]   RegSrc;
    logic [1:0]   ALUControl;
    logic [3:0]   Flags;
    logic [3:0]   State;

    modport master (
        input  Instr, ALUFlags, MemReady,
        output PCWrite, IRWrite, RegWrite, MemWrite,
        output AdrSrc, ALUSrcA, ResultSrc, ALUSrcB,
        output ImmSrc, RegSrc, ALUControl, Flags, State
    );

    modport slave (
        output Instr, ALUFlags, MemReady,
        input  PCWrite, IRWrite, RegWrite, MemWrite,
        input  AdrSrc, ALUSrcA, ResultSrc, ALUSrcB,
        input  ImmSrc, RegSrc, ALUControl, Flags, State
    );

endinterface

// File: rtl/mc_condcheck.sv
// Combinational ARM condition evaluation.
// Ports: cond (4b code), flags ({N,Z,C,V}), cond_ex (1 = execute).
module mc_condcheck (
    input  logic [3:0] cond,
    input  logic [3:0] flags,
    output logic       cond_ex
);

    logic n, z, c, v;

    assign {n, z, c, v} = flags;

    always_comb begin
        cond_ex = 1'b0;
        unique case (cond)
            4'h0: cond_ex = z;
            4'h1: cond_ex = ~z;
            4'h2: cond_ex = c;
            4'h3: cond_ex = ~c;
            4'h4: cond_ex = n;
            4'h5: cond_ex = ~n;
            4'h6: cond_ex = v;
            4'h7: cond_ex = ~v;
            4'h8: cond_ex = c & ~z;
            4'h9: cond_ex = ~c | z;
            4'hA: cond_ex = ~(n ^ v);
            4'hB: cond_ex = n ^ v;
            4'hC: cond_ex = ~z & ~(n ^ v);
            4'hD: cond_ex = z | (n ^ v);
            4'hE: cond_ex = 1'b1;
            4'hF: cond_ex = 1'b0;
        endcase
    end

endmodule

// File: rtl/mc_controller.sv
// Multicycle ARM-subset controller: FSM, flags register, strobes.
// Ports: clk, reset (async, low), Instr[31:12], ALUFlags, MemReady in;
// write strobes, mux selects, ALUControl, Flags and State out.
module mc_controller
    import mc_pkg::*;
#(
    parameter logic [3:0] FLAGS_RST = 4'b0000
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [31:12] Instr,
    input  logic [3:0]   ALUFlags,
    input  logic         MemReady,
    output logic         PCWrite,
    output logic         IRWrite,
    output logic         RegWrite,
    output logic         MemWrite,
    output logic         AdrSrc,
    output logic         ALUSrcA,
    output logic [1:0]   ResultSrc,
    output logic [1:0]   ALUSrcB,
    output logic [1:0]   ImmSrc,
    output logic [1:0]   RegSrc,
    output logic [1:0]   ALUControl,
    output logic [3:0]   Flags,
    output logic [3:0]   State
);

    state_t     state, state_nx;
    logic [3:0] flags;
    logic [3:0] cond;
    logic [1:0] op;
    logic [5:0] funct;
    logic [3:0] cmd;
    logic [3:0] rd;
    logic       cond_ex;
    logic       flag_we;
    logic       arith;
    logic       pc_w, ir_w, reg_w, mem_w;
    logic       unused_rn;

    assign cond      = Instr[31:28];
    assign op        = Instr[27:26];
    assign funct     = Instr[25:20];
    assign rd        = Instr[15:12];
    assign cmd       = funct[4:1];
    assign unused_rn = ^Instr[19:16];

    mc_condcheck u_cond (
        .cond    (cond),
        .flags   (flags),
        .cond_ex (cond_ex)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state <= FETCH;
        else        state <= state_nx;
    end

    // Flags latch at the end of an execute cycle with S set;
    // logical ops leave C and V alone.
    assign flag_we = ((state == EXECR) || (state == EXECI)) & funct[0];
    assign arith   = (cmd == CMD_ADD) || (cmd == CMD_SUB);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            flags <= FLAGS_RST;
        end else if (flag_we) begin
            flags[3:2] <= ALUFlags[3:2];
            if (arith) flags[1:0] <= ALUFlags[1:0];
        end
    end

    // Immediate/register-source selects follow the opcode in every
    // state so later cycles see the same extension as DECODE.
    always_comb begin
        ImmSrc = 2'b00;
        RegSrc = 2'b00;
        unique case (1'b1)
            (op == OP_MEM): begin
                ImmSrc = 2'b01;
                RegSrc = 2'b10;
            end
            (op == OP_BR): begin
                ImmSrc = 2'b10;
                RegSrc = 2'b01;
            end
            default: begin
                ImmSrc = 2'b00;
                RegSrc = 2'b00;
            end
        endcase
    end

    always_comb begin
        state_nx   = state;
        pc_w       = 1'b0;
        ir_w       = 1'b0;
        reg_w      = 1'b0;
        mem_w      = 1'b0;
        AdrSrc     = 1'b0;
        ALUSrcA    = 1'b0;
        ALUSrcB    = SRCB_REG;
        ALUControl = ALU_ADD;
        ResultSrc  = RES_ALUOUT;
        unique case (state)
            FETCH: begin
                ALUSrcA = 1'b1;
                ALUSrcB = SRCB_PLUS4;
                ir_w    = MemReady;
                pc_w    = MemReady;
                if (MemReady) state_nx = DECODE;
            end
            DECODE: begin
                if (!cond_ex)                      state_nx = FETCH;
                else if (op == OP_NOP)             state_nx = FETCH;
                else if (op == OP_DP && !dp_ok(cmd)) state_nx = FETCH;
                else if (op == OP_MEM)             state_nx = MEMADR;
                else if (op == OP_DP)
                    state_nx = funct[5] ? EXECI : EXECR;
                else                               state_nx = BRANCH;
            end
            MEMADR: begin
                ALUSrcB  = SRCB_EXTIMM;
                state_nx = funct[0] ? MEMRD : MEMWR;
            end
            MEMRD: begin
                AdrSrc = 1'b1;
                if (MemReady) state_nx = MEMWB;
            end
            MEMWB: begin
                ResultSrc = RES_DATA;
                reg_w     = 1'b1;
                pc_w      = (rd == 4'd15);
                state_nx  = FETCH;
            end
            MEMWR: begin
                AdrSrc = 1'b1;
                mem_w  = 1'b1;
                if (MemReady) state_nx = FETCH;
            end
            EXECR: begin
                ALUControl = alu_op(cmd);
                state_nx   = ALUWB;
            end
            EXECI: begin
                ALUSrcB    = SRCB_EXTIMM;
                ALUControl = alu_op(cmd);
                state_nx   = ALUWB;
            end
            ALUWB: begin
                ResultSrc = RES_ALUOUT;
                reg_w     = 1'b1;
                pc_w      = (rd == 4'd15);
                state_nx  = FETCH;
            end
            BRANCH: begin
                ALUSrcB   = SRCB_EXTIMM;
                ResultSrc = RES_ALURESULT;
                pc_w      = 1'b1;
                state_nx  = FETCH;
            end
            default: state_nx = FETCH;
        endcase
    end

    // Strobes are gated by reset directly so an abandoned access
    // stops in the same cycle reset is pulled.
    assign PCWrite  = pc_w  & reset;
    assign IRWrite  = ir_w  & reset;
    assign RegWrite = reg_w & reset;
    assign MemWrite = mem_w & reset;
    assign Flags    = flags;
    assign State    = state;

endmodule
